// File: rtl/mux32_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux32_serial_ctrl
// Function : Steps an external MUX32 select across a captured word and returns
//            the selected bit as a valid/ready serial stream.
// Revision : 1.0 - initial release
// ============================================================================
module mux32_serial_ctrl #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_in_data,
   input  logic [4:0]  i_in_len,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic        i_abort,
   output logic [31:0] o_mux_in,
   output logic [4:0]  o_mux_sel,
   input  logic        i_mux_out,
   output logic        o_ser_bit,
   output logic        o_ser_valid,
   input  logic        i_ser_ready,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_mux_in;
   logic [4:0]  r_mux_sel;
   logic [4:0]  r_len;
   logic [4:0]  r_cnt;

   logic        w_accept;
   logic        w_beat;
   logic        w_last;
   logic [4:0]  w_first_sel;
   logic [4:0]  w_step_sel;

   assign w_accept    = (r_state == S_IDLE) && i_in_valid;
   assign w_beat      = (r_state == S_SHIFT) && i_ser_ready;
   assign w_last      = (r_cnt == r_len);
   assign w_first_sel = LSB_FIRST ? 5'd0 : i_in_len;
   assign w_step_sel  = LSB_FIRST ? (r_mux_sel + 5'd1) : (r_mux_sel - 5'd1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (i_abort)              w_state_nxt = S_IDLE;
            else if (w_beat && w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // The select only advances on a taken beat that is not the last one, so it
   // never wraps past the final bit position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mux_in  <= 32'd0;
         r_mux_sel <= 5'd0;
         r_len     <= 5'd0;
         r_cnt     <= 5'd0;
      end else if (w_accept) begin
         r_mux_in  <= i_in_data;
         r_mux_sel <= w_first_sel;
         r_len     <= i_in_len;
         r_cnt     <= 5'd0;
      end else if (w_beat && !w_last && !i_abort) begin
         r_mux_sel <= w_step_sel;
         r_cnt     <= r_cnt + 5'd1;
      end
   end

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_ser_valid = (r_state == S_SHIFT);
   assign o_ser_bit   = i_mux_out;
   assign o_busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
   assign o_done      = (r_state == S_DONE);
   assign o_mux_in    = r_mux_in;
   assign o_mux_sel   = r_mux_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux32_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux32_serial_ctrl
// Function : Self-checking bench for both select directions of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux32_serial_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data   [2];
   logic [4:0]  in_len    [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic        abort     [2];
   logic [31:0] mux_in    [2];
   logic [4:0]  mux_sel   [2];
   logic        mux_out   [2];
   logic        ser_bit   [2];
   logic        ser_valid [2];
   logic        ser_ready [2];
   logic        busy      [2];
   logic        done      [2];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural MUX32 in front of each controller
   assign mux_out[0] = mux_in[0][mux_sel[0]];
   assign mux_out[1] = mux_in[1][mux_sel[1]];

   mux32_serial_ctrl #(.LSB_FIRST(1'b1)) u_up (
      .clk(clk), .rst_n(rst_n),
      .i_in_data(in_data[0]), .i_in_len(in_len[0]), .i_in_valid(in_valid[0]),
      .o_in_ready(in_ready[0]), .i_abort(abort[0]),
      .o_mux_in(mux_in[0]), .o_mux_sel(mux_sel[0]), .i_mux_out(mux_out[0]),
      .o_ser_bit(ser_bit[0]), .o_ser_valid(ser_valid[0]), .i_ser_ready(ser_ready[0]),
      .o_busy(busy[0]), .o_done(done[0])
   );

   mux32_serial_ctrl #(.LSB_FIRST(1'b0)) u_dn (
      .clk(clk), .rst_n(rst_n),
      .i_in_data(in_data[1]), .i_in_len(in_len[1]), .i_in_valid(in_valid[1]),
      .o_in_ready(in_ready[1]), .i_abort(abort[1]),
      .o_mux_in(mux_in[1]), .o_mux_sel(mux_sel[1]), .i_mux_out(mux_out[1]),
      .o_ser_bit(ser_bit[1]), .o_ser_valid(ser_valid[1]), .i_ser_ready(ser_ready[1]),
      .o_busy(busy[1]), .o_done(done[1])
   );

   typedef struct {
      int          k;         // 0: LSB-first instance, 1: MSB-first instance
      logic [31:0] d;
      logic [4:0]  len;
      int          bp;        // 0: ready held, 1: ready toggles 1/0, 2: random
      int          abort_at;  // beat index that carries abort, -1 none
      logic [31:0] exp_bits;  // bit i = i-th emitted bit
      bit          use_exp;
      bit          ab_idle;   // abort raised alongside in_valid in IDLE
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected stream: i-th bit comes from position i (LSB-first) or len-i.
   task automatic run_word(input vec_t v);
      logic [4:0] sel_q[$];
      logic       bit_q[$];
      int         nbits;
      int         idx;
      int         cyc;
      bit         finished;
      bit         aborted;
      bit         rdy;
      bit         ab;
      logic       eb;
      int         k;
      k     = v.k;
      nbits = int'(v.len) + 1;
      for (int i = 0; i < nbits; i++) begin
         int s;
         s = (k == 0) ? i : int'(v.len) - i;
         sel_q.push_back(s[4:0]);
         bit_q.push_back(v.d[s]);
      end

      check("idle_in_ready", 32'(in_ready[k]), 32'd1);
      in_valid[k]  = 1'b1;
      in_data[k]   = v.d;
      in_len[k]    = v.len;
      abort[k]     = v.ab_idle;
      ser_ready[k] = 1'b0;
      tick();
      in_valid[k] = 1'b0;
      abort[k]    = 1'b0;
      in_data[k]  = $urandom;
      in_len[k]   = 5'($urandom);

      idx = 0; cyc = 0; finished = 0; aborted = 0;
      while (!finished && cyc < 400) begin
         eb = v.use_exp ? v.exp_bits[idx] : bit_q[idx];
         check("ser_valid", 32'(ser_valid[k]), 32'd1);
         check("busy_shift", 32'(busy[k]), 32'd1);
         check("done_early", 32'(done[k]), 32'd0);
         check("ser_bit", 32'(ser_bit[k]), 32'(eb));
         check("mux_sel", 32'(mux_sel[k]), 32'(sel_q[idx]));
         check("mux_in", mux_in[k], v.d);
         if (v.bp == 0)      rdy = 1'b1;
         else if (v.bp == 1) rdy = (cyc % 2 == 0);
         else                rdy = 1'($urandom);
         ab = rdy && (idx == v.abort_at);
         ser_ready[k] = rdy;
         abort[k]     = ab;
         tick();
         ser_ready[k] = 1'b0;
         abort[k]     = 1'b0;
         cyc++;
         if (rdy) begin
            idx++;
            if (ab) begin finished = 1; aborted = 1; end
            else if (idx == nbits) finished = 1;
         end
      end
      if (!finished) begin
         check("word_timeout", 32'(idx), 32'(nbits));
      end else if (aborted) begin
         check("abort_ser_valid", 32'(ser_valid[k]), 32'd0);
         check("abort_done", 32'(done[k]), 32'd0);
         check("abort_in_ready", 32'(in_ready[k]), 32'd1);
         check("abort_busy", 32'(busy[k]), 32'd0);
      end else begin
         check("done_pulse", 32'(done[k]), 32'd1);
         check("done_ser_valid", 32'(ser_valid[k]), 32'd0);
         check("done_in_ready", 32'(in_ready[k]), 32'd0);
         check("done_busy", 32'(busy[k]), 32'd1);
         tick();
         check("done_once", 32'(done[k]), 32'd0);
         check("ready_back", 32'(in_ready[k]), 32'd1);
         check("idle_busy", 32'(busy[k]), 32'd0);
         check("idle_ser_valid", 32'(ser_valid[k]), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      vec_t rv;
      tbl[0] = '{0, 32'hEE0E5EA0, 5'd7,  0, -1, 32'h000000A0, 1'b1, 1'b0};
      tbl[1] = '{1, 32'h0607A061, 5'd7,  0, -1, 32'h00000086, 1'b1, 1'b0};
      tbl[2] = '{0, 32'hEEEEEEEE, 5'd31, 1, -1, 32'hEEEEEEEE, 1'b1, 1'b0};
      tbl[3] = '{0, 32'h100200E5, 5'd0,  0, -1, 32'h00000001, 1'b1, 1'b0};
      tbl[4] = '{0, 32'hD0D020E0, 5'd31, 0,  2, 32'h00000000, 1'b0, 1'b0};
      tbl[5] = '{0, 32'h12345678, 5'd5,  0, -1, 32'h00000000, 1'b0, 1'b1};
      tbl[6] = '{1, 32'hEEEEEEEE, 5'd31, 2, -1, 32'h00000000, 1'b0, 1'b0};
      tbl[7] = '{1, 32'h80000001, 5'd0,  1, -1, 32'h00000001, 1'b1, 1'b0};

      for (int k = 0; k < 2; k++) begin
         in_data[k] = '0; in_len[k] = '0; in_valid[k] = 1'b0;
         abort[k] = 1'b0; ser_ready[k] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_in_ready", 32'(in_ready[k]), 32'd1);
         check("rst_ser_valid", 32'(ser_valid[k]), 32'd0);
         check("rst_busy", 32'(busy[k]), 32'd0);
         check("rst_done", 32'(done[k]), 32'd0);
         check("rst_mux_in", mux_in[k], 32'd0);
         check("rst_mux_sel", 32'(mux_sel[k]), 32'd0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_word(tbl[i]);

      for (int i = 0; i < 24; i++) begin
         rv.k        = int'($urandom_range(0, 1));
         rv.d        = $urandom;
         rv.len      = 5'($urandom);
         rv.bp       = 2;
         rv.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rv.len))) : -1;
         rv.exp_bits = 32'd0;
         rv.use_exp  = 1'b0;
         rv.ab_idle  = 1'($urandom);
         run_word(rv);
      end

      // Asynchronous reset in the middle of a word
      in_valid[0] = 1'b1; in_data[0] = 32'hFFFFFFFF; in_len[0] = 5'd31;
      ser_ready[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      tick();
      check("pre_rst_valid", 32'(ser_valid[0]), 32'd1);
      check("pre_rst_sel", 32'(mux_sel[0]), 32'd2);
      rst_n = 1'b0;
      #1;
      check("midrst_ser_valid", 32'(ser_valid[0]), 32'd0);
      check("midrst_mux_sel", 32'(mux_sel[0]), 32'd0);
      check("midrst_mux_in", mux_in[0], 32'd0);
      check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_done", 32'(done[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ser_ready[0] = 1'b0;
      tick();
      check("postrst_ser_valid", 32'(ser_valid[0]), 32'd0);
      check("postrst_done", 32'(done[0]), 32'd0);
      run_word(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
